// File: rtl/counter_ctrl.sv
// Bundling-pass controller: flushes the counter, gates per-core store strobes, waits out
// the counter pipeline, then holds the captured sign until the consumer accepts it.
// Optional STORE watchdog enabled by defining COUNTER_CTRL_TIMEOUT_EN (adds port timeout).
module counter_ctrl #(
  parameter int CORENUM = 16,
  parameter int W       = 30,
  parameter int DRAIN   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       num_store,
  input  logic [CORENUM-1:0] core_en,
  input  logic [CORENUM-1:0] core_valid,
  input  logic               sign_bit,
  input  logic               out_ready,
  output logic               flush,
  output logic [CORENUM-1:0] store,
  output logic               core_ack,
  output logic               busy,
  output logic               sign_valid,
  output logic               sign_out,
  output logic               done
`ifdef COUNTER_CTRL_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STORE,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_cnt;
  logic [W-1:0]       r_cnt_tgt;
  logic [CORENUM-1:0] r_en;
  logic [DCW-1:0]     r_drain;
  logic               r_sign;
  logic               w_fire;
  logic               w_last;

  // Disabled cores count as always valid, so an all-zero mask fires every STORE cycle.
  assign w_fire = (r_state == S_STORE) && (&(core_valid | ~r_en));
  assign w_last = ((r_cnt + W'(1)) == r_cnt_tgt);

`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       w_timeout;

  assign w_timeout = (r_state == S_STORE) && !w_fire && (r_wd == 8'hFF);
  assign timeout   = w_timeout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cnt_tgt <= '0;
      r_en      <= '0;
      r_drain   <= '0;
      r_sign    <= 1'b0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
      r_wd      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt_tgt <= num_store;
            r_en      <= core_en;
            r_state   <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_cnt   <= '0;
          r_drain <= '0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
          r_wd    <= '0;
`endif
          r_state <= (r_cnt_tgt == '0) ? S_DRAIN : S_STORE;
        end
        S_STORE: begin
          if (w_fire) begin
            r_cnt <= r_cnt + W'(1);
`ifdef COUNTER_CTRL_TIMEOUT_EN
            r_wd  <= '0;
`endif
            if (w_last) begin
              r_drain <= '0;
              r_state <= S_DRAIN;
            end
          end
`ifdef COUNTER_CTRL_TIMEOUT_EN
          else if (r_wd == 8'hFF) begin
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
`endif
        end
        S_DRAIN: begin
          if (r_drain == DCW'(DRAIN - 1)) begin
            r_sign  <= sign_bit;
            r_state <= S_OUTPUT;
          end else begin
            r_drain <= r_drain + DCW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign flush      = (r_state == S_FLUSH);
  assign store      = w_fire ? r_en : '0;
  assign core_ack   = w_fire;
  assign busy       = (r_state != S_IDLE);
  assign sign_valid = (r_state == S_OUTPUT);
  assign sign_out   = r_sign;
  assign done       = (r_state == S_OUTPUT) && out_ready;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: timestamp-based pass model checked every cycle,
// directed scenarios with literal latencies, then randomized traffic.
module tb_counter_ctrl;
  localparam int CN = 16;
  localparam int W  = 30;
  localparam int DR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  num_store = '0;
  logic [CN-1:0] core_en = '0;
  logic [CN-1:0] core_valid = '0;
  logic          sign_bit = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush;
  logic [CN-1:0] store;
  logic          core_ack;
  logic          busy;
  logic          sign_valid;
  logic          sign_out;
  logic          done;
`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic          timeout;
`endif

  counter_ctrl #(.CORENUM(CN), .W(W), .DRAIN(DR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_store  (num_store),
    .core_en    (core_en),
    .core_valid (core_valid),
    .sign_bit   (sign_bit),
    .out_ready  (out_ready),
    .flush      (flush),
    .store      (store),
    .core_ack   (core_ack),
    .busy       (busy),
    .sign_valid (sign_valid),
    .sign_out   (sign_out),
    .done       (done)
`ifdef COUNTER_CTRL_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Pass model: a pass is described by when it flushes, how many batches remain,
  // and the cycle its result becomes visible.
  bit            m_active = 1'b0;
  int            m_flush_at = 0;
  int            m_left = 0;
  int            m_result_at = 0;
  int            m_wd = 0;
  logic [CN-1:0] m_en = '0;
  logic          m_sign = 1'b0;
  logic          e_flush, e_ack, e_sv, e_done, e_to, e_busy, fire, go_idle;
  logic [CN-1:0] e_store;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_flush", 32'(flush), 0);
      chk("rst_store", 32'(store), 0);
      chk("rst_ack", 32'(core_ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sv", 32'(sign_valid), 0);
      chk("rst_sign", 32'(sign_out), 0);
      chk("rst_done", 32'(done), 0);
`ifdef COUNTER_CTRL_TIMEOUT_EN
      chk("rst_timeout", 32'(timeout), 0);
`endif
      m_active = 1'b0;
    end else begin
      e_flush = 1'b0; e_store = '0; e_ack = 1'b0; e_sv = 1'b0;
      e_done = 1'b0; e_to = 1'b0; go_idle = 1'b0;
      e_busy = m_active;
      fire = &(core_valid | ~m_en);
      if (m_active) begin
        if (cyc == m_flush_at) begin
          e_flush = 1'b1;
        end else if (m_left > 0) begin
          if (fire) begin
            e_store = m_en;
            e_ack = 1'b1;
            m_left--;
            m_wd = 0;
            if (m_left == 0) m_result_at = cyc + 1 + DR;
          end
`ifdef COUNTER_CTRL_TIMEOUT_EN
          else if (m_wd == 255) begin
            e_to = 1'b1;
            go_idle = 1'b1;
          end else begin
            m_wd++;
          end
`endif
        end else if (cyc < m_result_at) begin
          if (cyc == m_result_at - 1) m_sign = sign_bit;
        end else begin
          e_sv = 1'b1;
          e_done = out_ready;
          go_idle = out_ready;
        end
      end
      chk("flush", 32'(flush), 32'(e_flush));
      chk("store", 32'(store), 32'(e_store));
      chk("core_ack", 32'(core_ack), 32'(e_ack));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("sign_valid", 32'(sign_valid), 32'(e_sv));
      chk("done", 32'(done), 32'(e_done));
      if (e_sv) chk("sign_out", 32'(sign_out), 32'(m_sign));
`ifdef COUNTER_CTRL_TIMEOUT_EN
      chk("timeout", 32'(timeout), 32'(e_to));
`endif
      if (go_idle) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_flush_at = cyc + 1;
        m_left = int'(num_store);
        m_en = core_en;
        m_wd = 0;
        m_result_at = (num_store == '0) ? cyc + 2 + DR : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sv(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (sign_valid === 1'b1) at = cyc;
    end
  endtask

  // Let the current pass finish with one accepting cycle.
  task automatic finish_pass();
    int at;
    wait_sv(80, at);
    if (at < 0) chk("sv_wait", 32'(sign_valid), 1);
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;
  endtask

`ifdef COUNTER_CTRL_TIMEOUT_EN
  task automatic wait_to(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) at = cyc;
    end
  endtask
`endif

  int t0, at;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal: 4 full batches
    sign_bit = 1'b1;
    start = 1'b1; num_store = W'(4); core_en = '1; core_valid = '1; t0 = cyc;
    tick(); start = 1'b0;
    @(negedge clk); chk("nom_flush_t1", 32'(flush), 1);
    tick();
    @(negedge clk); chk("nom_store_t2", 32'(store), 32'hFFFF);
    wait_sv(40, at);
    chk("nom_sv_latency", 32'(at - t0), 9);
    chk("nom_sign", 32'(sign_out), 1);
    tick(); out_ready = 1'b1;
    @(negedge clk); chk("nom_done", 32'(done), 1);
    tick(); out_ready = 1'b0;
    @(negedge clk); chk("nom_idle", 32'(busy), 0);

    // Stalled core 3
    sign_bit = 1'b0;
    tick(); start = 1'b1; num_store = W'(2); core_en = 16'h000F; core_valid = 16'h0007;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk); chk("stall_nostore", 32'(store), 0);
    end
    tick(); core_valid = 16'h000F;
    @(negedge clk); chk("stall_store", 32'(store), 32'h000F);
    finish_pass();

    // Zero batches
    tick(); start = 1'b1; num_store = '0; core_en = 16'h00FF; core_valid = '0; t0 = cyc;
    tick(); start = 1'b0;
    wait_sv(20, at);
    chk("zero_sv_latency", 32'(at - t0), 5);
    chk("zero_sign", 32'(sign_out), 0);
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;

    // Backpressure with ignored starts, including one coincident with done
    tick(); start = 1'b1; num_store = W'(2); core_en = '1; core_valid = '1; sign_bit = 1'b1;
    tick(); start = 1'b0;
    wait_sv(30, at);
    for (int i = 0; i < 10; i++) begin
      tick(); start = 1'($urandom_range(0, 1)); num_store = W'($urandom_range(0, 5));
      @(negedge clk); chk("bp_hold", 32'(sign_valid), 1);
    end
    tick(); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk("bp_done", 32'(done), 1);
    tick(); start = 1'b0; out_ready = 1'b0;
    @(negedge clk); chk("bp_idle", 32'(busy), 0);

    // Reset mid-STORE, then restart two cycles after release
    tick(); start = 1'b1; num_store = W'(3); core_en = 16'h00FF; core_valid = '0;
    tick(); start = 1'b0;
    tick(); tick();
    tick(); rst = 1'b1;
    #1 chk("rst_async_busy", 32'(busy), 0);
    tick(); tick(); rst = 1'b0;
    tick(); tick(); start = 1'b1; core_valid = '1;
    tick(); start = 1'b0;
    @(negedge clk); chk("rst_restart_flush", 32'(flush), 1);
    finish_pass();

    // Empty enable mask
    tick(); start = 1'b1; num_store = W'(3); core_en = '0; core_valid = 16'h1234;
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); chk("en0_ack", 32'(core_ack), 1);
    end
    finish_pass();

`ifdef COUNTER_CTRL_TIMEOUT_EN
    tick(); start = 1'b1; num_store = W'(2); core_en = 16'h0001; core_valid = '0; t0 = cyc;
    tick(); start = 1'b0;
    wait_to(300, at);
    chk("to_latency", 32'(at - (t0 + 2)), 255);
    @(negedge clk); chk("to_busy", 32'(busy), 0);
`else
    tick(); start = 1'b1; num_store = W'(2); core_en = 16'h0001; core_valid = '0;
    tick(); start = 1'b0;
    repeat (300) @(negedge clk);
    chk("no_to_busy", 32'(busy), 1);
    tick(); core_valid = '1;
    finish_pass();
`endif

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tick();
      rst        = ($urandom_range(0, 499) == 0);
      start      = ($urandom_range(0, 3) == 0);
      num_store  = W'($urandom_range(0, 5));
      core_en    = ($urandom_range(0, 7) == 0) ? '0 : CN'($urandom);
      core_valid = ($urandom_range(0, 3) != 0) ? '1 : CN'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
      sign_bit   = 1'($urandom_range(0, 1));
    end
    tick(); rst = 1'b0; start = 1'b0; core_valid = '1; out_ready = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter CORENUM, default 16, number of cores feeding the counter.
REQ-002 Parameter W, default 30, width of num_store and the internal batch counter.
REQ-003 Parameter DRAIN, default 3, cycles from the last store pulse until sign_bit is final.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 start  in  1  one-cycle request to run a bundling pass.
REQ-007 num_store  in  W  number of store batches in the pass; sampled with start.
REQ-008 core_en  in  CORENUM  cores taking part in the pass; sampled with start.
REQ-009 core_valid  in  CORENUM  per-core result-ready flags.
REQ-010 sign_bit  in  1  sign output of the counter.
REQ-011 out_ready  in  1  consumer accepts sign_out.
REQ-012 flush  out  1  clears the counter accumulators; wired to the counter's rst.
REQ-013 store  out  CORENUM  per-core store strobes to the counter.
REQ-014 core_ack  out  1  marks the batch consumed in this cycle.
REQ-015 busy  out  1  a pass is in progress (state is not IDLE).
REQ-016 sign_valid  out  1  sign_out holds the final result.
REQ-017 sign_out  out  1  captured sign of the bundled sum.
REQ-018 done  out  1  one-cycle pulse when the result handshake completes.

Function
REQ-019 The FSM SHALL have five states: IDLE, FLUSH, STORE, DRAIN and OUTPUT.
REQ-020 IDLE: start=1 SHALL latch num_store and core_en (into cnt_tgt and en_r) and move to FLUSH; otherwise stay in IDLE.
REQ-021 FLUSH: flush SHALL be 1 for exactly one cycle, then go to STORE; if cnt_tgt==0, go to DRAIN instead.
REQ-022 STORE: fire SHALL be 1 when all enabled cores are valid, i.e. &(core_valid | ~en_r).
REQ-023 On fire, store SHALL equal en_r and core_ack SHALL be 1 in the same cycle (combinational), and the batch count SHALL increment.
REQ-024 Without fire, store SHALL be 0 and core_ack SHALL be 0, and the FSM stays in STORE.
REQ-025 STORE SHALL go to DRAIN on the fire that makes the batch count equal cnt_tgt.
REQ-026 DRAIN SHALL last exactly DRAIN cycles; in the last of them sign_out SHALL register sign_bit, then go to OUTPUT.
REQ-027 OUTPUT: sign_valid SHALL be 1 and sign_out stable until out_ready=1.
REQ-028 The cycle with sign_valid and out_ready both 1 SHALL pulse done and return to IDLE; sign_valid falls the next cycle.
REQ-029 start in any state other than IDLE SHALL be ignored, including a start coincident with done.
REQ-030 en_r all zero: fire is true every STORE cycle with store=0; the pass completes after cnt_tgt cycles.
REQ-031 The batch count SHALL be W bits, compared for equality only, with no wrap-around beyond cnt_tgt.
REQ-032 Store latency: start at cycle t gives flush at t+1 and the earliest store at t+2.
REQ-033 Result latency: with all cores valid, sign_valid rises cnt_tgt+DRAIN+2 cycles after start.
REQ-034 flush, store and core_ack SHALL never be asserted in the same cycle.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE; batch count, cnt_tgt and en_r cleared to 0.
REQ-036 On rst=1, all outputs SHALL be 0.
REQ-037 Reset during any pass SHALL abort it with no done pulse; the counter is also cleared because it shares the system rst.

Configuration
REQ-038 Macro COUNTER_CTRL_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog in STORE.
REQ-039 The watchdog SHALL clear on every fire or STORE entry and increment on each cycle without fire.
REQ-040 When the watchdog reaches 255, the block SHALL abort to IDLE, pulse output timeout for one cycle, and not assert done or sign_valid.
REQ-041 Without the macro, STORE SHALL wait indefinitely, and the timeout port and its logic SHALL be absent.

Verification
REQ-042 Reset mid-STORE: pass running, assert rst -> all outputs 0 immediately; start 2 cycles after release -> flush at the following cycle.
REQ-043 Nominal run: core_en=16'hFFFF, num_store=4, core_valid held all-ones -> flush at t+1; store=16'hFFFF at t+2..t+5; sign_valid from t+9 (t+4+DRAIN+2).
REQ-044 Stalled core: core_en=16'h000F, core_valid=16'h0007 for 5 cycles then 16'h000F -> no store in those 5 cycles; store=16'h000F once core 3 is valid.
REQ-045 Zero batches: num_store=0 -> FLUSH, then DRAIN, then OUTPUT with sign_out=0 and no store pulse.
REQ-046 Backpressure: out_ready=0 for 10 cycles in OUTPUT -> sign_valid held; start pulses during those cycles ignored; out_ready=1 -> done for 1 cycle, then IDLE.
REQ-047 COUNTER_CTRL_TIMEOUT_EN defined, core_valid=0 -> timeout pulse 255 cycles after STORE entry, busy=0 the next cycle, no done.
